inst_fetch: RTL

Instruction fetch unit directly upstream of the instruction decoder. It reads opcode and argument bytes from byte-wide program memory over a req/ack handshake and assembles them into a 16-bit instruction word. It presents that word with a valid strobe that drives the decoder enable, then advances the program counter by instruction length or branch target once the core retires the instruction.

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch.sv | 114 +++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared fetch definitions: state encodings, opcode length rule, default reset PC
package inst_fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_VALID     = 3'd3,
        ST_HALTED    = 3'd4
    } fetch_state_t;

    // Opcode bit selecting 2-byte instructions; must match the decoder's length rule.
    localparam int OP_LEN_BIT   = 7;
    localparam int INST_LEN_BIT = 8 + OP_LEN_BIT;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    function automatic logic [1:0] op_len(input logic [7:0] opcode);
        return opcode[OP_LEN_BIT] ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-wide instruction fetch: assembles {opcode, arg} words and advances the PC on retire
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic [1:0]  inst_len,
    output logic [15:0] inst_pc,
    input  logic        inst_ready,
    input  logic        branch_take,
    input  logic [15:0] branch_offset,
    input  logic        halt,
    output logic        halted
);

    fetch_state_t state;
    fetch_state_t next_state;

    logic [15:0] pc;
    logic [15:0] addr_q;
    logic [15:0] inst_q;
    logic [1:0]  len_q;
    logic [15:0] inst_pc_q;
    logic [15:0] next_pc;

    logic op_accept;
    logic arg_accept;
    logic retire;

    assign op_accept  = (state == ST_FETCH_OP)  && mem_ack;
    assign arg_accept = (state == ST_FETCH_ARG) && mem_ack;
    assign retire     = (state == ST_VALID)     && inst_ready;

    assign next_pc = branch_take ? (inst_pc_q + branch_offset)
                                 : (inst_pc_q + {14'd0, len_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_BOOT:      next_state = ST_FETCH_OP;
            ST_FETCH_OP: begin
                if (mem_ack) begin
                    next_state = (op_len(mem_rdata) == 2'd2) ? ST_FETCH_ARG : ST_VALID;
                end
            end
            ST_FETCH_ARG: begin
                if (mem_ack) begin
                    next_state = ST_VALID;
                end
            end
            ST_VALID: begin
                if (inst_ready) begin
                    next_state = halt ? ST_HALTED : ST_FETCH_OP;
                end
            end
            ST_HALTED:    next_state = ST_HALTED;
            default:      next_state = ST_BOOT;
        endcase
    end

    // addr_q tracks the outstanding request address so it only moves on an accepted ack or a retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            addr_q    <= RESET_PC;
            inst_q    <= 16'h0000;
            len_q     <= 2'd1;
            inst_pc_q <= RESET_PC;
        end else begin
            if (op_accept) begin
                inst_q[15:8] <= mem_rdata;
                inst_pc_q    <= pc;
                len_q        <= op_len(mem_rdata);
                if (op_len(mem_rdata) == 2'd2) begin
                    addr_q <= pc + 16'd1;
                end else begin
                    inst_q[7:0] <= 8'h00;
                end
            end
            if (arg_accept) begin
                inst_q[7:0] <= mem_rdata;
            end
            if (retire && !halt) begin
                pc     <= next_pc;
                addr_q <= next_pc;
            end
        end
    end

    assign mem_req    = (state == ST_FETCH_OP) || (state == ST_FETCH_ARG);
    assign mem_addr   = addr_q;
    assign inst       = inst_q;
    assign inst_len   = len_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = (state == ST_VALID);
    assign halted     = (state == ST_HALTED);

endmodule
